// File: rtl/binary_fibonacci.sv
// Binary-to-Zeckendorf encoder: greedy MSB-first subtraction, one code bit per clock.
// The Fibonacci weight pair (a, b) is walked downwards so no ROM or multiplier is needed.
module binary_fibonacci #(
   parameter int FB_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FB_WIDTH-1:0] input_b,
   input  logic                en_convert,
   output logic                busy,
   output logic                convert_done,
   output logic                overflow,
   output logic [FB_WIDTH-1:0] f_b_out
);

   localparam logic [FB_WIDTH-1:0] W_TOP   = FB_WIDTH'(3524578);
   localparam logic [FB_WIDTH-1:0] W_NEXT  = FB_WIDTH'(2178309);
   localparam logic [FB_WIDTH-1:0] MAX_VAL = FB_WIDTH'(5702886);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      FINISH
   } state_t;

   state_t              state, state_next;
   logic [FB_WIDTH-1:0] rem, rem_next;
   logic [FB_WIDTH-1:0] code, code_next;
   logic [FB_WIDTH-1:0] a, a_next;
   logic [FB_WIDTH-1:0] b, b_next;
   logic [4:0]          cnt, cnt_next;
   logic                ovf_job, ovf_job_next;
   logic                done_next, overflow_next;
   logic [FB_WIDTH-1:0] f_b_out_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         rem          <= '0;
         code         <= '0;
         a            <= '0;
         b            <= '0;
         cnt          <= 5'd31;
         ovf_job      <= 1'b0;
         convert_done <= 1'b0;
         overflow     <= 1'b0;
         f_b_out      <= '0;
      end else begin
         state        <= state_next;
         rem          <= rem_next;
         code         <= code_next;
         a            <= a_next;
         b            <= b_next;
         cnt          <= cnt_next;
         ovf_job      <= ovf_job_next;
         convert_done <= done_next;
         overflow     <= overflow_next;
         f_b_out      <= f_b_out_next;
      end
   end

   // A new request is refused during the done-pulse cycle, leaving one idle cycle between jobs.
   always_comb begin
      state_next    = state;
      rem_next      = rem;
      code_next     = code;
      a_next        = a;
      b_next        = b;
      cnt_next      = cnt;
      ovf_job_next  = ovf_job;
      done_next     = 1'b0;
      overflow_next = 1'b0;
      f_b_out_next  = f_b_out;

      unique case (state)
         IDLE: begin
            if (en_convert && !convert_done) begin
               if (input_b <= MAX_VAL) begin
                  rem_next     = input_b;
                  code_next    = '0;
                  cnt_next     = 5'd31;
                  a_next       = W_TOP;
                  b_next       = W_NEXT;
                  ovf_job_next = 1'b0;
                  state_next   = CONVERT;
               end else begin
                  ovf_job_next = 1'b1;
                  state_next   = FINISH;
               end
            end
         end

         CONVERT: begin
            if (rem >= a) begin
               code_next[cnt] = 1'b1;
               rem_next       = rem - a;
            end
            a_next   = b;
            b_next   = a - b;
            cnt_next = cnt - 5'd1;
            if (cnt == 5'd0) begin
               state_next = FINISH;
            end
         end

         FINISH: begin
            done_next = 1'b1;
            if (ovf_job) begin
               f_b_out_next  = '0;
               overflow_next = 1'b1;
            end else begin
               f_b_out_next  = code;
               overflow_next = 1'b0;
            end
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE) || convert_done;

endmodule

// File: tb/tb_binary_fibonacci.sv
// Self-checking bench for binary_fibonacci: cycle-level timeline model plus
// directed literal vectors and Zeckendorf property checks on random jobs.
module tb_binary_fibonacci;

   localparam logic [31:0] MAX_VAL = 32'd5702886;

   logic        clk;
   logic        rst;
   logic [31:0] input_b;
   logic        en_convert;
   logic        busy;
   logic        convert_done;
   logic        overflow;
   logic [31:0] f_b_out;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: cycles left until the done pulse, and the job's expected outcome
   int          left = 0;
   logic        exp_done = 1'b0;
   logic        exp_ovf  = 1'b0;
   logic        exp_busy = 1'b0;
   logic [31:0] exp_fb   = '0;
   logic        job_ovf  = 1'b0;
   logic [31:0] job_code = '0;
   logic [31:0] job_val  = '0;

   binary_fibonacci #(.FB_WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .input_b      (input_b),
      .en_convert   (en_convert),
      .busy         (busy),
      .convert_done (convert_done),
      .overflow     (overflow),
      .f_b_out      (f_b_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint weight(input int i);
      longint w0 = 1;
      longint w1 = 2;
      longint t;
      if (i == 0) return 1;
      for (int k = 2; k <= i; k++) begin
         t  = w0 + w1;
         w0 = w1;
         w1 = t;
      end
      return w1;
   endfunction

   function automatic logic [31:0] zeck(input logic [31:0] v);
      logic [31:0] c = '0;
      longint r = longint'(v);
      for (int i = 31; i >= 0; i--) begin
         if (r >= weight(i)) begin
            c[i] = 1'b1;
            r    = r - weight(i);
         end
      end
      return c;
   endfunction

   function automatic longint fib_sum(input logic [31:0] c);
      longint s = 0;
      for (int i = 0; i < 32; i++) begin
         if (c[i]) s = s + weight(i);
      end
      return s;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Timeline model: acceptance needs an idle, non-done cycle; done follows 33 (or 1) edges later
   initial begin
      logic prev_done;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            left     = 0;
            exp_done = 1'b0;
            exp_ovf  = 1'b0;
            exp_fb   = '0;
            exp_busy = 1'b0;
         end else begin
            prev_done = exp_done;
            exp_done  = 1'b0;
            exp_ovf   = 1'b0;
            if (left > 0) begin
               left--;
               if (left == 0) begin
                  exp_done = 1'b1;
                  exp_ovf  = job_ovf;
                  exp_fb   = job_ovf ? 32'd0 : job_code;
               end
            end else if (!prev_done && en_convert) begin
               job_val  = input_b;
               job_ovf  = (input_b > MAX_VAL);
               job_code = job_ovf ? 32'd0 : zeck(input_b);
               left     = job_ovf ? 1 : 33;
            end
            exp_busy = (left > 0) || exp_done;
         end
      end
   end

   // Per-cycle comparison against the model, plus Zeckendorf properties on each normal result
   initial begin
      forever begin
         @(negedge clk);
         check_output("busy", 32'(busy), 32'(exp_busy));
         check_output("convert_done", 32'(convert_done), 32'(exp_done));
         check_output("overflow", 32'(overflow), 32'(exp_ovf));
         check_output("f_b_out", f_b_out, exp_fb);
         if (exp_done && !exp_ovf) begin
            check_output("no_adjacent_ones", f_b_out & (f_b_out >> 1), 32'd0);
            check_output("weighted_sum", 32'(fib_sum(f_b_out)), job_val);
         end
      end
   end

   task automatic apply_stimulus(input logic [31:0] value, input bit pin,
                                 input logic [31:0] lit, input logic lit_ovf,
                                 input int exp_lat, input int exp_busy_cycles);
      int  edges = 0;
      int  busy_cnt = 0;
      bit  got = 0;
      @(negedge clk);
      input_b    = value;
      en_convert = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en_convert = 1'b0;
      input_b    = $urandom;
      for (int k = 0; k < 60 && !got; k++) begin
         if (busy) busy_cnt++;
         if (convert_done) got = 1;
         else begin
            @(negedge clk);
            edges++;
         end
      end
      check_output("done_seen", 32'(got), 32'd1);
      check_output("latency", 32'(edges), 32'(exp_lat));
      if (pin) begin
         check_output("f_b_out_literal", f_b_out, lit);
         check_output("overflow_literal", 32'(overflow), 32'(lit_ovf));
      end
      @(negedge clk);
      check_output("busy_after_done", 32'(busy), 32'd0);
      check_output("busy_cycles", 32'(busy_cnt), 32'(exp_busy_cycles));
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  edges;
      bit  got;
      rst        = 1'b0;
      en_convert = 1'b0;
      input_b    = '0;
      repeat (3) @(negedge clk);
      check_output("reset_f_b_out", f_b_out, 32'd0);
      check_output("reset_done", 32'(convert_done), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      rst = 1'b1;

      apply_stimulus(32'd0,       1, 32'h0000_0000, 1'b0, 33, 34);
      apply_stimulus(32'd1,       1, 32'h0000_0001, 1'b0, 33, 34);
      apply_stimulus(32'd4,       1, 32'h0000_0005, 1'b0, 33, 34);
      apply_stimulus(32'd100,     1, 32'h0000_0214, 1'b0, 33, 34);
      apply_stimulus(32'd5702886, 1, 32'hAAAA_AAAA, 1'b0, 33, 34);
      apply_stimulus(32'd5702887, 1, 32'h0000_0000, 1'b1, 1, 2);

      // en_convert held high; input_b changes mid-job, then a second job starts after one idle cycle
      @(negedge clk);
      input_b    = 32'd20;
      en_convert = 1'b1;
      @(posedge clk);
      @(negedge clk);
      input_b = 32'd7;
      got = 0;
      for (int k = 0; k < 60 && !got; k++) begin
         if (convert_done) got = 1;
         else @(negedge clk);
      end
      check_output("hold_done_seen", 32'(got), 32'd1);
      check_output("hold_latched_value", f_b_out, 32'h0000_002A);
      @(negedge clk);
      check_output("gap_busy_low", 32'(busy), 32'd0);
      @(negedge clk);
      check_output("back_to_back_busy", 32'(busy), 32'd1);
      en_convert = 1'b0;
      got   = 0;
      edges = 0;
      for (int k = 0; k < 60 && !got; k++) begin
         if (convert_done) got = 1;
         else begin
            @(negedge clk);
            edges++;
         end
      end
      check_output("b2b_done_seen", 32'(got), 32'd1);
      check_output("b2b_latency", 32'(edges), 32'd33);
      check_output("b2b_result", f_b_out, 32'h0000_000A);
      @(negedge clk);

      // Abort a job part-way with an asynchronous reset
      input_b    = 32'd100;
      en_convert = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en_convert = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_done", 32'(convert_done), 32'd0);
      check_output("abort_overflow", 32'(overflow), 32'd0);
      check_output("abort_f_b_out", f_b_out, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      apply_stimulus(32'd12, 1, 32'h0000_0015, 1'b0, 33, 34);

      for (int j = 0; j < 1500; j++) begin
         apply_stimulus(32'($urandom_range(5702886, 0)), 0, 32'd0, 1'b0, 33, 34);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
